note_recorder: RTL and testbench
================================

NOTE_RECORDER -- requirements
Module: note_recorder

Interface
REQ-001 Parameter DATA_WIDTH, default 10, width of one note word (octave + note one-hot, 0 = silence).
REQ-002 Parameter DEPTH, default 192, number of note slots stored.
REQ-003 Parameter SAMPLE_DIV, default 12500000, clocks per captured slot (60 bpm x 8).
REQ-004 Port clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 Port rst  input  1  asynchronous, active-high reset.
REQ-006 Port rec_start  input  1  one-clock pulse; begins a new recording.
REQ-007 Port rec_stop  input  1  one-clock pulse; ends the current recording.
REQ-008 Port note_in  input  DATA_WIDTH  live keyboard note word.
REQ-009 Port read_en  input  1  level; enables playback of the recorded take.
REQ-010 Port read_rst  input  1  one-clock pulse; rewinds playback to slot 0.
REQ-011 Port data_out  output  DATA_WIDTH  registered playback word.
REQ-012 Port output_ready  output  1  data_out valid.
REQ-013 Port recording  output  1  high in ARMED or RECORD.
REQ-014 Port full  output  1  high once count == DEPTH.
REQ-015 Port count  output  9  slots stored in the current take.

Function
REQ-016 FSM states IDLE, ARMED, RECORD, DONE; storage is a DEPTH x DATA_WIDTH register array.
REQ-017 IDLE/DONE + rec_start: count <= 0, full <= 0, sample counter <= 1, playback pointer <= 0, output_ready <= 0, next state per REQ-030.
REQ-018 RECORD: sample counter increments each clock; when counter == SAMPLE_DIV, mem[count] <= note_in, count <= count+1, counter <= 1.
REQ-019 Write that makes count == DEPTH: same edge full <= 1, state <= DONE; no write ever at address >= DEPTH.
REQ-020 ARMED or RECORD + rec_stop: state <= DONE next edge; partial interval discarded, count unchanged.
REQ-021 rec_stop and rec_start same cycle: rec_stop wins; rec_start ignored in ARMED/RECORD.
REQ-022 Coinciding rec_stop and slot-write edge in RECORD: write performed, then DONE.
REQ-023 Playback only in IDLE/DONE: with read_en and pointer < count, output_ready <= 1, data_out <= mem[pointer], playback counter increments; at SAMPLE_DIV pointer advances and counter <= 1.
REQ-024 Playback with pointer >= count or count == 0: output_ready <= 0, data_out holds.
REQ-025 read_en low: pointer, counter, data_out, output_ready hold.
REQ-026 read_rst: pointer <= 0, playback counter <= 1, output_ready <= 0; takes priority over read_en.
REQ-027 In ARMED/RECORD: read_en ignored, output_ready held 0.

Reset
REQ-028 rst asserted (any time, including mid-recording): state IDLE, count 0, full 0, recording 0, output_ready 0, data_out 0, pointer 0, both counters 1.
REQ-029 Memory contents not cleared by reset; unreadable since count = 0.

Configuration
REQ-030 Macro NOTE_RECORDER_ARM_ON_NOTE_EN defined: rec_start enters ARMED; ARMED moves to RECORD on first clock note_in != 0, counter <= 1, no write that edge. Undefined: rec_start enters RECORD directly, ARMED unreachable.

Verification (SAMPLE_DIV=4, DEPTH=8)
REQ-031 Macro undefined, rec_start, note_in=10'h004 held 40 clocks -> after 4*8 clocks count=8, full=1, state DONE, recording=0.
REQ-032 Record 3 slots 0x004,0x010,0x040 then rec_stop, read_en high -> data_out 0x004,0x010,0x040 each 4 clocks, then output_ready=0.
REQ-033 rec_start and rec_stop same cycle while RECORD, count=2 -> DONE, count=2, no restart.
REQ-034 Macro defined, rec_start, note_in=0 for 10 clocks then 0x008 -> recording=1 throughout, first write 4 clocks after note edge, mem[0]=0x008.
REQ-035 rst pulsed mid-RECORD at count=5, then read_en -> count=0, output_ready stays 0.
REQ-036 read_rst during playback at pointer=2 -> output_ready=0 next clock, playback restarts with mem[0].

Source files
------------

// File: rtl/note_recorder.sv
// Note recorder: samples a live note word every SAMPLE_DIV clocks into a slot array, then plays the take back.
// Build option NOTE_RECORDER_ARM_ON_NOTE_EN: rec_start waits in ARMED until the first non-silent note.
module note_recorder #(
    parameter int DATA_WIDTH = 10,
    parameter int DEPTH      = 192,
    parameter int SAMPLE_DIV = 12500000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rec_start,
    input  logic                  rec_stop,
    input  logic [DATA_WIDTH-1:0] note_in,
    input  logic                  read_en,
    input  logic                  read_rst,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  output_ready,
    output logic                  recording,
    output logic                  full,
    output logic [8:0]            count
);

    localparam int CW = $clog2(SAMPLE_DIV + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DIV_C   = CW'(SAMPLE_DIV);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [8:0]    DEPTH_C = 9'(DEPTH);

    typedef enum logic [1:0] {IDLE, ARMED, RECORD, DONE} state_t;

    state_t                  state_reg, state_next;
    logic [CW-1:0]           rec_cnt_reg, play_cnt_reg;
    logic [8:0]              count_reg, ptr_reg;
    logic                    full_reg, ready_reg;
    logic [DATA_WIDTH-1:0]   data_reg;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic idle_like, start_take, slot_tick, last_slot;

    assign idle_like  = (state_reg == IDLE) || (state_reg == DONE);
    assign start_take = idle_like && rec_start;
    assign slot_tick  = (state_reg == RECORD) && (rec_cnt_reg == DIV_C);
    assign last_slot  = slot_tick && (count_reg == DEPTH_C - 9'd1);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (rec_start) begin
`ifdef NOTE_RECORDER_ARM_ON_NOTE_EN
                    state_next = ARMED;
`else
                    state_next = RECORD;
`endif
                end
            end
            ARMED: begin
                if (rec_stop)
                    state_next = DONE;
                else if (note_in != '0)
                    state_next = RECORD;
            end
            RECORD: begin
                // a stop coinciding with a slot edge still lets that slot be written
                if (rec_stop || last_slot)
                    state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            count_reg   <= '0;
            full_reg    <= 1'b0;
            rec_cnt_reg <= CNT_ONE;
        end else begin
            state_reg <= state_next;
            if (start_take) begin
                count_reg   <= '0;
                full_reg    <= 1'b0;
                rec_cnt_reg <= CNT_ONE;
            end else if (state_reg == ARMED) begin
                rec_cnt_reg <= CNT_ONE;
            end else if (slot_tick) begin
                count_reg   <= count_reg + 9'd1;
                rec_cnt_reg <= CNT_ONE;
                if (last_slot)
                    full_reg <= 1'b1;
            end else if (state_reg == RECORD) begin
                rec_cnt_reg <= rec_cnt_reg + CNT_ONE;
            end
        end
    end

    // Slot storage is deliberately left out of reset; count gates every read.
    always_ff @(posedge clk) begin
        if (slot_tick && (count_reg < DEPTH_C))
            mem[count_reg[AW-1:0]] <= note_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg      <= '0;
            play_cnt_reg <= CNT_ONE;
            ready_reg    <= 1'b0;
            data_reg     <= '0;
        end else if (start_take) begin
            ptr_reg      <= '0;
            play_cnt_reg <= CNT_ONE;
            ready_reg    <= 1'b0;
        end else if (!idle_like) begin
            ready_reg <= 1'b0;
        end else if (read_rst) begin
            ptr_reg      <= '0;
            play_cnt_reg <= CNT_ONE;
            ready_reg    <= 1'b0;
        end else if (read_en) begin
            if (ptr_reg < count_reg) begin
                ready_reg <= 1'b1;
                data_reg  <= mem[ptr_reg[AW-1:0]];
                if (play_cnt_reg == DIV_C) begin
                    ptr_reg      <= ptr_reg + 9'd1;
                    play_cnt_reg <= CNT_ONE;
                end else begin
                    play_cnt_reg <= play_cnt_reg + CNT_ONE;
                end
            end else begin
                ready_reg <= 1'b0;
            end
        end
    end

    assign data_out     = data_reg;
    assign output_ready = ready_reg;
    assign recording    = (state_reg == ARMED) || (state_reg == RECORD);
    assign full         = full_reg;
    assign count        = count_reg;

endmodule

// File: tb/tb_note_recorder.sv
// Directed bench for note_recorder with SAMPLE_DIV=4, DEPTH=8.
module tb_note_recorder;

    localparam int DW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rec_start = 1'b0;
    logic          rec_stop = 1'b0;
    logic [DW-1:0] note_in = '0;
    logic          read_en = 1'b0;
    logic          read_rst = 1'b0;
    logic [DW-1:0] data_out;
    logic          output_ready;
    logic          recording;
    logic          full;
    logic [8:0]    count;

    int n_checks = 0;
    int n_errors = 0;

    note_recorder #(.DATA_WIDTH(DW), .DEPTH(8), .SAMPLE_DIV(4)) dut (
        .clk(clk), .rst(rst), .rec_start(rec_start), .rec_stop(rec_stop),
        .note_in(note_in), .read_en(read_en), .read_rst(read_rst),
        .data_out(data_out), .output_ready(output_ready), .recording(recording),
        .full(full), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
        n_checks++;
        if (obs !== exp_val) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_val);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_take(input logic [DW-1:0] note);
        note_in   = note;
        rec_start = 1'b1;
        tick();
        rec_start = 1'b0;
    endtask

    logic [DW-1:0] exp_notes [3];

    initial begin
        exp_notes[0] = 10'h004;
        exp_notes[1] = 10'h010;
        exp_notes[2] = 10'h040;

        tick(2);
        rst = 1'b0;
        check("rst_count", 32'(count), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_recording", 32'(recording), 32'd0);
        check("rst_ready", 32'(output_ready), 32'd0);
        check("rst_data", 32'(data_out), 32'd0);

        // Fill all 8 slots: one write every 4 clocks
        start_take(10'h004);
        check("fill_recording", 32'(recording), 32'd1);
        for (int i = 1; i <= 32; i++) begin
            tick();
            check($sformatf("fill_count_%0d", i), 32'(count), 32'(i / 4));
        end
        check("fill_full", 32'(full), 32'd1);
        check("fill_recording_off", 32'(recording), 32'd0);
        tick(8);
        check("fill_count_hold", 32'(count), 32'd8);

        // Three-note take then playback
        start_take(exp_notes[0]);
        check("take_full_clr", 32'(full), 32'd0);
        tick(4);
        note_in = exp_notes[1];
        tick(4);
        note_in = exp_notes[2];
        tick(4);
        rec_stop = 1'b1;
        tick();
        rec_stop = 1'b0;
        check("take_count", 32'(count), 32'd3);
        check("take_recording", 32'(recording), 32'd0);

        read_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check($sformatf("play_ready_%0d", i), 32'(output_ready), 32'd1);
            check($sformatf("play_data_%0d", i), 32'(data_out), 32'(exp_notes[i / 4]));
        end
        tick();
        check("play_end_ready", 32'(output_ready), 32'd0);
        check("play_end_data", 32'(data_out), 32'h040);

        // Rewind, play into slot 2, then rewind again mid-playback
        read_rst = 1'b1;
        tick();
        read_rst = 1'b0;
        tick(9);
        check("mid_data", 32'(data_out), 32'h040);
        read_en = 1'b0;
        tick(3);
        check("hold_ready", 32'(output_ready), 32'd1);
        check("hold_data", 32'(data_out), 32'h040);
        read_en = 1'b1;
        read_rst = 1'b1;
        tick();
        read_rst = 1'b0;
        check("rew_ready", 32'(output_ready), 32'd0);
        tick();
        check("rew_ready2", 32'(output_ready), 32'd1);
        check("rew_data", 32'(data_out), 32'h004);
        read_en = 1'b0;

        // Stop landing on a slot edge keeps that slot
        start_take(10'h011);
        tick(3);
        rec_stop = 1'b1;
        tick();
        rec_stop = 1'b0;
        check("edge_stop_count", 32'(count), 32'd1);
        check("edge_stop_rec", 32'(recording), 32'd0);

        // Start and stop together while recording: stop wins
        start_take(10'h021);
        tick(8);
        check("ss_count_pre", 32'(count), 32'd2);
        rec_start = 1'b1;
        rec_stop  = 1'b1;
        tick();
        rec_start = 1'b0;
        rec_stop  = 1'b0;
        check("ss_recording", 32'(recording), 32'd0);
        tick(6);
        check("ss_count", 32'(count), 32'd2);

        // Asynchronous reset in the middle of a take
        start_take(10'h002);
        tick(20);
        check("ar_count_pre", 32'(count), 32'd5);
        #2;
        rst = 1'b1;
        #1;
        check("ar_count", 32'(count), 32'd0);
        check("ar_recording", 32'(recording), 32'd0);
        tick();
        rst = 1'b0;
        read_en = 1'b1;
        tick(5);
        check("ar_ready", 32'(output_ready), 32'd0);
        read_en = 1'b0;

`ifdef NOTE_RECORDER_ARM_ON_NOTE_EN
        start_take(10'h000);
        tick(10);
        check("arm_recording", 32'(recording), 32'd1);
        check("arm_count", 32'(count), 32'd0);
        note_in = 10'h008;
        tick(4);
        check("arm_count_pre", 32'(count), 32'd0);
        tick();
        check("arm_count_first", 32'(count), 32'd1);
        rec_stop = 1'b1;
        tick();
        rec_stop = 1'b0;
        read_en = 1'b1;
        tick();
        check("arm_mem0", 32'(data_out), 32'h008);
        read_en = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
